// File: rtl/vga_fbfetch_pkg.sv
// ==== vga_define : shared fetch FSM states, AXI response codes, beat size | rev 1.0 ====
`default_nettype none

package vga_define;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_AR    = 3'd2,
    ST_R     = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int BEAT_BYTES = 8;

  // Two 32bpp pixels per beat; an odd pixel count rounds up to a whole beat.
  function automatic logic [31:0] frame_beats(input logic [15:0] hvlen, input logic [15:0] vvlen);
    logic [31:0] px;
    px = ({16'd0, hvlen} + 32'd1) * ({16'd0, vvlen} + 32'd1);
    return (px + 32'd1) >> 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_fbfetch_if.sv
// ==== vga_fbfetch_if : AXI read address/data channels of the frame fetcher | rev 1.0 ====
`default_nettype none

interface vga_fbfetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] araddr_o;
  logic [7:0]            arlen_o;
  logic                  arvalid_o;
  logic                  arready_i;
  logic [DATA_WIDTH-1:0] rdata_i;
  logic [1:0]            rresp_i;
  logic                  rlast_i;
  logic                  rvalid_i;
  logic                  rready_o;

  modport master (
    output araddr_o, arlen_o, arvalid_o, rready_o,
    input  arready_i, rdata_i, rresp_i, rlast_i, rvalid_i
  );

  modport slave (
    input  araddr_o, arlen_o, arvalid_o, rready_o,
    output arready_i, rdata_i, rresp_i, rlast_i, rvalid_i
  );
endinterface

`default_nettype wire

// File: rtl/vga_fbfetch_burst_calc.sv
// ==== vga_burst_calc : burst length = min(brulen, remain-1[, 4K boundary-1]) | rev 1.0 ====
// ==== boundary clamp enabled by VGA_FBFETCH_4K_SPLIT_EN                          ====
`default_nettype none

module vga_burst_calc (
  input  logic [11:0] addr,
  input  logic [31:0] remain,
  input  logic [7:0]  brulen,
  output logic [7:0]  len
);

  logic [31:0] rem_m1;

`ifdef VGA_FBFETCH_4K_SPLIT_EN
  logic [12:0] bnd_m1;

  always_comb begin
    rem_m1 = remain - 32'd1;
    len    = brulen;
    if (rem_m1 < {24'd0, brulen}) len = rem_m1[7:0];
    // Beats left before the next 4 KB page; addr is 8-byte aligned so this is >= 1.
    bnd_m1 = ((13'd4096 - {1'b0, addr}) >> 3) - 13'd1;
    if ({19'd0, bnd_m1} < {24'd0, len}) len = bnd_m1[7:0];
  end
`else
  logic unused_addr;
  assign unused_addr = ^addr;

  always_comb begin
    rem_m1 = remain - 32'd1;
    len    = brulen;
    if (rem_m1 < {24'd0, brulen}) len = rem_m1[7:0];
  end
`endif

endmodule

`default_nettype wire

// File: rtl/vga_fbfetch.sv
// ==== vga_fbfetch : AXI burst reader filling the VGA tx FIFO, double-buffered | rev 1.0 ====
// ==== optional 4 KB burst split: VGA_FBFETCH_4K_SPLIT_EN                        ====
`default_nettype none

module vga_fbfetch
  import vga_define::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic                         vbse_i,
  input  logic [ADDR_WIDTH-1:0]        fbba1_i,
  input  logic [ADDR_WIDTH-1:0]        fbba2_i,
  input  logic [15:0]                  hvlen_i,
  input  logic [15:0]                  vvlen_i,
  input  logic [7:0]                   brulen_i,
  input  logic [$clog2(FIFO_DEPTH):0]  fifo_cnt_i,
  vga_fbfetch_if.master                axi,
  output logic                         push_valid_o,
  output logic [DATA_WIDTH-1:0]        push_data_o,
  output logic                         cfb_o,
  output logic                         vbsirq_o,
  output logic                         err_o
);

  fetch_state_t          state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n, step;
  logic [31:0]           remain, remain_n, remain_adv, reload_beats;
  logic [7:0]            len, len_q, len_q_n;
  logic                  cfb, cfb_n, vbsirq, vbsirq_n;
  logic                  arvalid, rready, push_valid, resp_ok;
  int                    space;

  vga_burst_calc u_burst_calc (
    .addr   (addr[11:0]),
    .remain (remain),
    .brulen (brulen_i),
    .len    (len)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      addr   <= '0;
      remain <= '0;
      len_q  <= '0;
      cfb    <= 1'b0;
      vbsirq <= 1'b0;
    end else begin
      state  <= state_n;
      addr   <= addr_n;
      remain <= remain_n;
      len_q  <= len_q_n;
      cfb    <= cfb_n;
      vbsirq <= vbsirq_n;
    end
  end

  always_comb begin
    state_n      = state;
    addr_n       = addr;
    remain_n     = remain;
    len_q_n      = len_q;
    cfb_n        = cfb;
    vbsirq_n     = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    push_valid   = 1'b0;
    reload_beats = frame_beats(hvlen_i, vvlen_i);
    step         = ADDR_WIDTH'(({24'd0, len_q} + 32'd1) * 32'(BEAT_BYTES));
    remain_adv   = remain - ({24'd0, len_q} + 32'd1);
    space        = FIFO_DEPTH - int'(fifo_cnt_i);
    unique case (state)
      ST_IDLE: begin
        addr_n   = cfb ? fbba2_i : fbba1_i;
        remain_n = reload_beats;
        if (en_i) state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (!en_i)                        state_n = ST_IDLE;
        else if (space >= int'(len) + 1)  state_n = ST_AR;
      end
      ST_AR: begin
        // Once presented the request is never withdrawn, even if en_i drops.
        arvalid = 1'b1;
        if (axi.arready_i) begin
          len_q_n = len;
          state_n = en_i ? ST_R : ST_DRAIN;
        end
      end
      ST_R: begin
        rready     = 1'b1;
        push_valid = axi.rvalid_i;
        if (axi.rvalid_i && axi.rlast_i) begin
          addr_n   = addr + step;
          remain_n = remain_adv;
          if (remain_adv == 32'd0) begin
            if (vbse_i) begin
              cfb_n    = ~cfb;
              vbsirq_n = 1'b1;
            end
            addr_n   = cfb_n ? fbba2_i : fbba1_i;
            remain_n = reload_beats;
          end
          // Burst already complete, so a disable here needs no drain.
          state_n = en_i ? ST_WAIT : ST_IDLE;
        end else if (!en_i) begin
          state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        rready = 1'b1;
        if (axi.rvalid_i && axi.rlast_i) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign resp_ok       = (axi.rresp_i == RESP_OKAY) || (axi.rresp_i == RESP_EXOKAY);
  assign axi.arvalid_o = arvalid;
  assign axi.araddr_o  = arvalid ? addr : '0;
  assign axi.arlen_o   = arvalid ? len : 8'd0;
  assign axi.rready_o  = rready;
  assign push_valid_o  = push_valid;
  assign push_data_o   = push_valid ? axi.rdata_i : '0;
  assign cfb_o         = cfb;
  assign vbsirq_o      = vbsirq;
  assign err_o         = axi.rvalid_i && rready && !resp_ok;

endmodule

`default_nettype wire

// File: doc/vga_fbfetch.md
VGA_FBFETCH -- requirements
Module: vga_fbfetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: AXI read address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: AXI read data width (8-byte beats, two 32bpp pixels per beat).
REQ-003 SHALL have parameter FIFO_DEPTH, default 512: depth of the downstream tx FIFO, in beats.
REQ-004 SHALL declare ports as follows (clk_i single clock; rst_i synchronous, active-high):
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
en_i  in  1  fetch enable (CTRL.EN)
vbse_i  in  1  video bank switch enable
fbba1_i  in  ADDR_WIDTH  frame buffer base 1, 8-byte aligned
fbba2_i  in  ADDR_WIDTH  frame buffer base 2, 8-byte aligned
hvlen_i  in  16  visible pixels per line minus 1
vvlen_i  in  16  visible lines minus 1
brulen_i  in  8  maximum burst beats minus 1
fifo_cnt_i  in  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
araddr_o  out  ADDR_WIDTH  AR address
arlen_o  out  8  AR burst length
arvalid_o  out  1  AR valid
arready_i  in  1  AR ready
rdata_i  in  DATA_WIDTH  R data
rresp_i  in  2  R response
rlast_i  in  1  R last
rvalid_i  in  1  R valid
rready_o  out  1  R ready
push_valid_o  out  1  FIFO push strobe
push_data_o  out  DATA_WIDTH  FIFO push data
cfb_o  out  1  current frame buffer (0 = fbba1, 1 = fbba2)
vbsirq_o  out  1  one-cycle bank-switch pulse
err_o  out  1  one-cycle pulse on any R beat with rresp_i[1] = 1

Function
REQ-005 SHALL implement FSM IDLE, WAIT, AR, R, DRAIN.
REQ-006 IDLE: SHALL load addr = cfb ? fbba2_i : fbba1_i and remain = ((hvlen_i+1)*(vvlen_i+1)+1)>>1 beats (32-bit arithmetic), then go to WAIT when en_i = 1.
REQ-007 SHALL compute len = min(brulen_i, remain-1, boundary-1) combinationally each cycle, where boundary = (4096 - addr[11:0])>>3.
REQ-008 WAIT: SHALL go to AR when FIFO_DEPTH - fifo_cnt_i >= len+1, guaranteeing a full burst always fits.
REQ-009 AR: SHALL hold arvalid_o = 1 with araddr_o/arlen_o stable until arready_i; on handshake SHALL latch len and go to R.
REQ-010 R: rready_o SHALL be 1; each rvalid_i beat SHALL drive push_valid_o = 1 and push_data_o = rdata_i combinationally (zero latency).
REQ-011 On the rlast_i beat SHALL update addr += (len+1)*8 and remain -= len+1; if remain becomes 0, SHALL perform end-of-frame, otherwise go to WAIT.
REQ-012 End-of-frame: if vbse_i = 1, SHALL toggle cfb_o and pulse vbsirq_o for one cycle; SHALL reload addr/remain from the new base and go to WAIT.
REQ-013 Only one burst SHALL be outstanding; arvalid_o SHALL be 0 outside AR.
REQ-014 en_i deasserting in IDLE/WAIT SHALL go to IDLE next cycle; in AR, SHALL hold arvalid_o until the handshake (no AXI retraction) then go to DRAIN; in R, SHALL go to DRAIN.
REQ-015 DRAIN: rready_o = 1, push_valid_o = 0; on rlast_i SHALL go to IDLE. cfb_o SHALL be retained.
REQ-016 Error responses SHALL NOT stop the fetch; the beat SHALL still be pushed to preserve pixel alignment.
REQ-017 rlast_i arriving before the latched beat count SHALL be treated as burst end (counters advance by latched len+1).
REQ-018 Simultaneous rlast_i end-of-frame and en_i deassertion: DRAIN/IDLE SHALL take priority; vbsirq_o SHALL still pulse.

Reset
REQ-019 rst_i SHALL force state IDLE, addr = 0, remain = 0, cfb_o = 0, and all outputs to 0 except araddr_o = 0 and arlen_o = 0, on the next clk_i edge, regardless of bus state.

Configuration
REQ-020 With VGA_FBFETCH_4K_SPLIT_EN defined, the boundary term of REQ-007 SHALL apply; without it, len = min(brulen_i, remain-1) and software SHALL align frame buffers so that no burst crosses 4 KB.

Structure
REQ-021 The FSM state enum, AXI response codes (OKAY, EXOKAY, SLVERR, DECERR), and the beat byte count constant SHALL live in the shared vga_define package.
REQ-022 The burst length computation SHALL be a combinational sub-module vga_burst_calc (inputs: addr, remain, brulen; output: len).

Verification
REQ-023 hvlen=15, vvlen=1, brulen=7, fbba1=0x1000, ready slave: SHALL issue exactly 2 bursts at 0x1000/0x1040 with arlen=7, producing 16 pushes.
REQ-024 With 4K split: fbba1=0x0FF0, brulen=7, 16-beat frame: SHALL issue bursts arlen=1@0x0FF0, arlen=7@0x1000, arlen=5@0x1040.
REQ-025 fifo_cnt_i=505, FIFO_DEPTH=512, brulen=7: SHALL stay in WAIT with arvalid_o=0 until fifo_cnt_i<=504.
REQ-026 vbse=1, two frames: cfb_o SHALL toggle 0->1->0, vbsirq_o SHALL pulse once per frame, and the second frame SHALL read from fbba2.
REQ-027 en_i dropped on beat 3 of an 8-beat burst: SHALL push no further beats, SHALL accept up to rlast_i, SHALL reach IDLE, and SHALL issue no new AR.
REQ-028 rresp=SLVERR on beat 2: SHALL pulse err_o once, SHALL push the data, and SHALL continue the frame.
